// File: rtl/demux_pkg.sv
// Shared constants for the buffered 1:2 byte demux: select encoding and default geometry.
// No logic, no latency, no flow control of its own.
package demux_pkg;
    localparam logic SEL_A     = 1'b0;
    localparam logic SEL_B     = 1'b1;
    localparam int   DEF_WIDTH = 8;
    localparam int   DEF_DEPTH = 2;
endpackage

// File: rtl/demux_1_2_buf_if.sv
// Source and dual-destination handshake bundle for demux_1_2_buf.
// Slave modport is the demux side; master modport is the producer/consumer side.
interface demux_1_2_buf_if
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [CW-1:0]    a_count;
    logic [CW-1:0]    b_count;

    modport slave (
        input  in_data, in_sel, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );

    modport master (
        output in_data, in_sel, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );
endinterface

// File: rtl/demux_fifo.sv
// Per-channel FIFO: registered head, push visible one cycle later; push refused when full
// even during a same-cycle pop, pop ignored when empty. Storage cleared by reset.
module demux_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        // Simultaneous push and pop leaves occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= push_data;
        end
    end
endmodule

// File: rtl/demux_1_2_buf.sv
// Buffered 1:2 demux: each word steered by in_sel into channel A or B FIFO, visible next cycle.
// in_ready follows only the selected FIFO's full flag, so a stalled channel never blocks the other.
module demux_1_2_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    demux_1_2_buf_if.slave   bus
);
    logic a_full, a_empty, b_full, b_empty;
    logic push_a, push_b, accept;

    assign bus.in_ready = !rst && ((bus.in_sel == SEL_A) ? !a_full : !b_full);
    assign accept       = bus.in_valid && bus.in_ready;
    assign push_a       = accept && (bus.in_sel == SEL_A);
    assign push_b       = accept && (bus.in_sel == SEL_B);

    assign bus.a_valid  = !a_empty;
    assign bus.b_valid  = !b_empty;

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (push_a),
        .push_data (bus.in_data),
        .pop       (bus.a_ready),
        .head_data (bus.a_data),
        .full      (a_full),
        .empty     (a_empty),
        .count     (bus.a_count)
    );

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (push_b),
        .push_data (bus.in_data),
        .pop       (bus.b_ready),
        .head_data (bus.b_data),
        .full      (b_full),
        .empty     (b_empty),
        .count     (bus.b_count)
    );
endmodule

// File: tb/tb_demux_1_2_buf.sv
// Scoreboarded bench for demux_1_2_buf: driver queues expected words per channel,
// a negedge monitor checks each output handshake against the queue head.
module tb_demux_1_2_buf;
    logic clk = 1'b0;
    logic rst = 1'b1;

    demux_1_2_buf_if #(.WIDTH(8), .DEPTH(2)) bus ();

    demux_1_2_buf #(.WIDTH(8), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Output monitor: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.a_valid && bus.a_ready) begin
                if (exp_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected: got %0h expected none", bus.a_data);
                end else begin
                    check("a_data", bus.a_data, exp_a.pop_front());
                end
            end
            if (bus.b_valid && bus.b_ready) begin
                if (exp_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected: got %0h expected none", bus.b_data);
                end else begin
                    check("b_data", bus.b_data, exp_b.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic s, input logic exp_rdy, input string nm);
        bus.in_data  = d;
        bus.in_sel   = s;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check(nm, bus.in_ready, exp_rdy);
        if (exp_rdy) begin
            if (s) exp_b.push_back(d);
            else   exp_a.push_back(d);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_data  = '0;
        bus.in_sel   = 1'b0;
        bus.in_valid = 1'b0;
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b0;

        // 1: reset state
        rst = 1'b1;
        step(); step();
        check("rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        #1;
        check("rst_a_valid", bus.a_valid, 0);
        check("rst_b_valid", bus.b_valid, 0);
        check("rst_a_count", bus.a_count, 0);
        check("rst_b_count", bus.b_count, 0);
        check("rst_a_data", bus.a_data, 0);
        check("rst_in_ready_a", bus.in_ready, 1);
        bus.in_sel = 1'b1;
        #1;
        check("rst_in_ready_b", bus.in_ready, 1);

        // 2: routing and 1-cycle latency
        send(8'h11, 1'b0, 1'b1, "t2_rdy0");
        check("t2_a_valid", bus.a_valid, 1);
        check("t2_a_data", bus.a_data, 8'h11);
        check("t2_b_valid", bus.b_valid, 0);
        send(8'h22, 1'b1, 1'b1, "t2_rdy1");
        check("t2_b_data", bus.b_data, 8'h22);
        check("t2_a_count", bus.a_count, 1);
        check("t2_b_count", bus.b_count, 1);
        bus.a_ready = 1'b1;
        bus.b_ready = 1'b1;
        step();
        bus.a_ready = 1'b0;
        bus.b_ready = 1'b0;
        check("t2_drain_a", bus.a_count, 0);
        check("t2_drain_b", bus.b_count, 0);

        // 3: full A refuses, B still accepted
        send(8'hA0, 1'b0, 1'b1, "t3_rdyA0");
        send(8'hA1, 1'b0, 1'b1, "t3_rdyA1");
        check("t3_a_count_full", bus.a_count, 2);
        send(8'hA2, 1'b0, 1'b0, "t3_rdyA2_refused");
        check("t3_a_count_hold", bus.a_count, 2);
        check("t3_a_head", bus.a_data, 8'hA0);
        send(8'hB0, 1'b1, 1'b1, "t3_rdyB0");
        check("t3_b_count", bus.b_count, 1);

        // 4: pop at full does not open in_ready in the same cycle
        bus.a_ready = 1'b1;
        send(8'hA2, 1'b0, 1'b0, "t4_rdy_full_pop");
        check("t4_a_count", bus.a_count, 1);
        send(8'hA2, 1'b0, 1'b1, "t4_rdy_accept");
        check("t4_a_count_pp", bus.a_count, 1);
        check("t4_a_head", bus.a_data, 8'hA2);
        bus.b_ready = 1'b1;
        step();
        bus.b_ready = 1'b0;
        check("t4_a_empty", bus.a_count, 0);
        check("t4_b_empty", bus.b_count, 0);

        // 5: streaming with pointer wrap
        for (int i = 0; i < 16; i++) begin
            send(8'(i), 1'b0, 1'b1, "t5_rdy");
            check("t5_a_head", bus.a_data, i);
        end
        step();
        bus.a_ready = 1'b0;
        check("t5_a_count", bus.a_count, 0);
        check("t5_queue_a", exp_a.size(), 0);

        // 6: reset mid-operation with a coincident handshake
        send(8'h31, 1'b0, 1'b1, "t6_rdy31");
        send(8'h32, 1'b0, 1'b1, "t6_rdy32");
        send(8'h41, 1'b1, 1'b1, "t6_rdy41");
        bus.in_data  = 8'h55;
        bus.in_sel   = 1'b1;
        bus.in_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("t6_in_ready_rst", bus.in_ready, 0);
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        exp_a.delete();
        exp_b.delete();
        #1;
        check("t6_a_count", bus.a_count, 0);
        check("t6_b_count", bus.b_count, 0);
        check("t6_a_valid", bus.a_valid, 0);
        check("t6_b_valid", bus.b_valid, 0);
        check("t6_a_data", bus.a_data, 0);
        check("t6_b_data", bus.b_data, 0);

        // Post-reset traffic still flows
        send(8'h66, 1'b1, 1'b1, "t6_rdy66");
        check("t6_b_head", bus.b_data, 8'h66);
        bus.b_ready = 1'b1;
        step();
        bus.b_ready = 1'b0;
        check("t6_queue_b", exp_b.size(), 0);
        check("t6_b_final", bus.b_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
